// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store at a time from EX, drives the RAM port, one response to WB.
// Latency from accept edge to the first resp_valid_o cycle: load 3, aligned store 2, split store N+1, reject/fault 1.
// Backpressure: req_ready_o is high only in IDLE. resp_valid_o and all response fields hold until resp_ready_i.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   req_valid_i/req_ready_o       request handshake; req_we_i, req_wid_i, req_addr_i, req_wdata_i carry the request
//   resp_valid_o/resp_ready_i     response handshake; resp_rdata_o, resp_misalign_o, resp_fault_o carry the response
//   ram_*_o / ram_*_i             RAM data port: byte address, enwr (0=write), enable, write data, width,
//                                 registered read data, and a combinational alignment error
module mem_access_unit #(
  parameter int RAM_SIZE         = 16,
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 64,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_wid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_misalign_o,
  output logic                  resp_fault_o,
  output logic [RAM_SIZE-1:0]   ram_addr_o,
  output logic                  ram_enwr_o,
  output logic                  ram_en_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [2:0]            ram_wid_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  input  logic                  ram_unalign_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SPLIT,
    S_RESP
  } state_t;

  state_t                state_q;
  logic                  we_q;
  logic [2:0]            wid_q;
  logic [RAM_SIZE-1:0]   addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            cnt_q;

  // Registered outputs
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  misalign_q;
  logic                  fault_q;
  logic [RAM_SIZE-1:0]   ram_addr_q;
  logic                  ram_enwr_q;
  logic                  ram_en_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [2:0]            ram_wid_q;

  assign req_ready_o     = req_ready_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign resp_misalign_o = misalign_q;
  assign resp_fault_o    = fault_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_enwr_o      = ram_enwr_q;
  assign ram_en_o        = ram_en_q;
  assign ram_wdata_o     = ram_wdata_q;
  assign ram_wid_o       = ram_wid_q;

  // Incoming request decode
  logic req_fire;
  logic req_oor;
  logic req_bad_wid;
  logic req_misal;

  assign req_fire = req_valid_i & req_ready_q;

  generate
    if (ADDR_WIDTH > RAM_SIZE) begin : g_range
      assign req_oor = |req_addr_i[ADDR_WIDTH-1:RAM_SIZE];
    end else begin : g_norange
      assign req_oor = 1'b0;
    end
  endgenerate

  // Unsigned widths are meaningless for stores; 111 is never legal.
  assign req_bad_wid = (req_wid_i == 3'b111) | (req_we_i & req_wid_i[2]);

  always_comb begin
    req_misal = 1'b0;
    case (req_wid_i)
      3'b001:  req_misal = req_addr_i[0];
      3'b010:  req_misal = |req_addr_i[1:0];
      3'b011:  req_misal = |req_addr_i[2:0];
      default: req_misal = 1'b0;
    endcase
    req_misal = req_misal & req_we_i;
  end

  // Split-store helpers
  logic [2:0] split_last_idx;
  logic [2:0] cnt_nxt;

  always_comb begin
    split_last_idx = 3'd7;
    case (wid_q)
      3'b001:  split_last_idx = 3'd1;
      3'b010:  split_last_idx = 3'd3;
      default: split_last_idx = 3'd7;
    endcase
  end

  assign cnt_nxt = cnt_q + 3'd1;

  function automatic logic [7:0] byte_sel(input logic [DATA_WIDTH-1:0] d, input logic [2:0] idx);
    logic [DATA_WIDTH-1:0] s;
    s = d >> {idx, 3'b000};
    return s[7:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      wid_q        <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 3'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      misalign_q   <= 1'b0;
      fault_q      <= 1'b0;
      ram_addr_q   <= '0;
      ram_enwr_q   <= 1'b1;
      ram_en_q     <= 1'b0;
      ram_wdata_q  <= '0;
      ram_wid_q    <= 3'b000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_fire) begin
            we_q        <= req_we_i;
            wid_q       <= req_wid_i;
            addr_q      <= req_addr_i[RAM_SIZE-1:0];
            wdata_q     <= req_wdata_i;
            cnt_q       <= 3'd0;
            req_ready_q <= 1'b0;
            if (req_oor || req_bad_wid) begin
              fault_q      <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else if (req_misal) begin
              if (SPLIT_MISALIGNED != 0) begin
                // First byte write goes out right away; later bytes follow from wdata_q.
                ram_en_q    <= 1'b1;
                ram_enwr_q  <= 1'b0;
                ram_wid_q   <= 3'b000;
                ram_addr_q  <= req_addr_i[RAM_SIZE-1:0];
                ram_wdata_q <= {{(DATA_WIDTH-8){1'b0}}, byte_sel(req_wdata_i, 3'd0)};
                state_q     <= S_SPLIT;
              end else begin
                misalign_q   <= 1'b1;
                resp_valid_q <= 1'b1;
                state_q      <= S_RESP;
              end
            end else begin
              ram_en_q    <= 1'b1;
              ram_enwr_q  <= ~req_we_i;
              ram_wid_q   <= req_wid_i;
              ram_addr_q  <= req_addr_i[RAM_SIZE-1:0];
              ram_wdata_q <= req_wdata_i;
              state_q     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          ram_en_q   <= 1'b0;
          ram_enwr_q <= 1'b1;
          fault_q    <= ram_unalign_i;
          if (we_q) begin
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A RAM alignment error leaves the load result at zero.
          if (!fault_q) begin
            resp_rdata_q <= ram_rdata_i;
          end
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end

        S_SPLIT: begin
          if (cnt_q == split_last_idx) begin
            ram_en_q     <= 1'b0;
            ram_enwr_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q       <= cnt_nxt;
            // Address arithmetic is RAM_SIZE bits wide so it wraps around the RAM.
            ram_addr_q  <= addr_q + RAM_SIZE'(cnt_nxt);
            ram_wdata_q <= {{(DATA_WIDTH-8){1'b0}}, byte_sel(wdata_q, cnt_nxt)};
          end
        end

        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            misalign_q   <= 1'b0;
            fault_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a behavioural RAM plus directed requests.
// Two instances are used: dut splits misaligned stores, dut0 rejects them.
// Responses are sampled on the falling edge; inputs change on the falling edge or just after the rising edge.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_valid0, req_we;
  logic [2:0]  req_wid;
  logic [63:0] req_addr, req_wdata;
  logic        resp_ready, resp_ready0;

  logic        req_ready, resp_valid, resp_misalign, resp_fault;
  logic [63:0] resp_rdata, ram_wdata, ram_rdata;
  logic [15:0] ram_addr;
  logic        ram_enwr, ram_en, ram_unalign;
  logic [2:0]  ram_wid;
  logic        unalign_inj;

  logic        req_ready0, resp_valid0, resp_misalign0, resp_fault0;
  logic [63:0] resp_rdata0, ram_wdata0, ram_rdata0;
  logic [15:0] ram_addr0;
  logic        ram_enwr0, ram_en0, ram_unalign0;
  logic [2:0]  ram_wid0;

  assign ram_unalign  = unalign_inj & ram_en;
  assign ram_rdata0   = '0;
  assign ram_unalign0 = 1'b0;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.RAM_SIZE(16), .DATA_WIDTH(64), .ADDR_WIDTH(64), .SPLIT_MISALIGNED(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we), .req_wid_i(req_wid),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_misalign_o(resp_misalign), .resp_fault_o(resp_fault),
    .ram_addr_o(ram_addr), .ram_enwr_o(ram_enwr), .ram_en_o(ram_en), .ram_wdata_o(ram_wdata),
    .ram_wid_o(ram_wid), .ram_rdata_i(ram_rdata), .ram_unalign_i(ram_unalign)
  );

  mem_access_unit #(.RAM_SIZE(16), .DATA_WIDTH(64), .ADDR_WIDTH(64), .SPLIT_MISALIGNED(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we), .req_wid_i(req_wid),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid0), .resp_ready_i(resp_ready0), .resp_rdata_o(resp_rdata0),
    .resp_misalign_o(resp_misalign0), .resp_fault_o(resp_fault0),
    .ram_addr_o(ram_addr0), .ram_enwr_o(ram_enwr0), .ram_en_o(ram_en0), .ram_wdata_o(ram_wdata0),
    .ram_wid_o(ram_wid0), .ram_rdata_i(ram_rdata0), .ram_unalign_i(ram_unalign0)
  );

  // Behavioural RAM: byte array, write on posedge, registered and width-extended read data.
  logic [7:0] mem [0:65535];

  function automatic int nbytes(input logic [2:0] w);
    case (w)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010, 3'b110: return 4;
      default:        return 8;
    endcase
  endfunction

  function automatic logic [63:0] rd(input logic [15:0] a, input logic [2:0] w);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = mem[16'(a + 16'(i))];
    case (w)
      3'b000:  return {{56{v[7]}}, v[7:0]};
      3'b001:  return {{48{v[15]}}, v[15:0]};
      3'b010:  return {{32{v[31]}}, v[31:0]};
      3'b011:  return v;
      3'b100:  return {56'h0, v[7:0]};
      3'b101:  return {48'h0, v[15:0]};
      3'b110:  return {32'h0, v[31:0]};
      default: return 64'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (!ram_enwr) begin
        for (int i = 0; i < nbytes(ram_wid); i++) mem[16'(ram_addr + 16'(i))] <= ram_wdata[i*8 +: 8];
      end else begin
        ram_rdata <= rd(ram_addr, ram_wid);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] wid, input logic [63:0] addr, input logic [63:0] wd);
    @(negedge clk);
    req_we = we; req_wid = wid; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Counts falling edges from the accept edge until resp_valid, bounded at 20.
  task automatic wait_resp(output int lat, output int ens, output logic [15:0] fa);
    lat = 0; ens = 0; fa = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ram_en === 1'b1) begin
        if (ens == 0) fa = ram_addr;
        ens++;
      end
      if (resp_valid === 1'b1) break;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({req_ready, resp_valid, ram_en, ram_enwr} !== 4'b1001) begin bad++;
      $display("FAIL reset_ctl: got %b want 1001", {req_ready, resp_valid, ram_en, ram_enwr}); end
    total++; if ({ram_addr, ram_wdata, ram_wid, resp_rdata, resp_misalign, resp_fault} !== '0) begin bad++;
      $display("FAIL reset_dat: addr=%h wdata=%h wid=%b rdata=%h mis=%b flt=%b want all 0",
               ram_addr, ram_wdata, ram_wid, resp_rdata, resp_misalign, resp_fault); end
    rst = 1'b0;
    @(negedge clk);
    total++; if ({req_ready, resp_valid, ram_en} !== 3'b100) begin bad++;
      $display("FAIL reset_idle: got %b want 100", {req_ready, resp_valid, ram_en}); end
  endtask

  task automatic test_load();
    int lat, ens; logic [15:0] fa;
    for (int i = 0; i < 8; i++) mem[16'h100 + i] = 8'(i + 1);
    issue(1'b0, 3'b011, 64'h100, 64'h0);
    wait_resp(lat, ens, fa);
    total++; if (lat !== 3 || ens !== 1 || fa !== 16'h100) begin bad++;
      $display("FAIL ld_timing: lat=%0d ens=%0d addr=%h want 3 1 0100", lat, ens, fa); end
    total++; if (resp_rdata !== 64'h0807060504030201 || resp_fault !== 1'b0 || resp_misalign !== 1'b0) begin bad++;
      $display("FAIL ld_data: got %h f=%b m=%b want 0807060504030201 0 0", resp_rdata, resp_fault, resp_misalign); end
    ack();
    total++; if ({req_ready, resp_valid, resp_rdata} !== {1'b1, 1'b0, 64'h0}) begin bad++;
      $display("FAIL ld_ack: ready=%b valid=%b rdata=%h want 1 0 0", req_ready, resp_valid, resp_rdata); end
    // Misaligned load still goes out as one access.
    issue(1'b0, 3'b010, 64'h105, 64'h0);
    wait_resp(lat, ens, fa);
    total++; if (lat !== 3 || ens !== 1 || resp_rdata !== 64'h0000000000080706) begin bad++;
      $display("FAIL ld_misal: lat=%0d ens=%0d rdata=%h want 3 1 0000000000080706", lat, ens, resp_rdata); end
    ack();
  endtask

  task automatic test_byte_loads();
    int lat, ens; logic [15:0] fa;
    mem[16'h10] = 8'h80;
    issue(1'b0, 3'b000, 64'h10, 64'h0);
    wait_resp(lat, ens, fa);
    total++; if (resp_rdata !== 64'hFFFFFFFFFFFFFF80) begin bad++;
      $display("FAIL lb: got %h want FFFFFFFFFFFFFF80", resp_rdata); end
    ack();
    issue(1'b0, 3'b100, 64'h10, 64'h0);
    wait_resp(lat, ens, fa);
    total++; if (resp_rdata !== 64'h80) begin bad++;
      $display("FAIL lbu: got %h want 0000000000000080", resp_rdata); end
    ack();
  endtask

  task automatic test_store_aligned();
    int lat, ens; logic [15:0] fa;
    issue(1'b1, 3'b011, 64'h300, 64'h1122334455667788);
    wait_resp(lat, ens, fa);
    total++; if (lat !== 2 || ens !== 1 || resp_rdata !== 64'h0 || resp_fault !== 1'b0) begin bad++;
      $display("FAIL sd_resp: lat=%0d ens=%0d rdata=%h f=%b want 2 1 0 0", lat, ens, resp_rdata, resp_fault); end
    ack();
    issue(1'b0, 3'b011, 64'h300, 64'h0);
    wait_resp(lat, ens, fa);
    total++; if (resp_rdata !== 64'h1122334455667788) begin bad++;
      $display("FAIL sd_readback: got %h want 1122334455667788", resp_rdata); end
    ack();
  endtask

  task automatic test_split_store();
    int lat, ens; logic [15:0] fa;
    issue(1'b1, 3'b010, 64'h203, 64'hDEADBEEF);
    wait_resp(lat, ens, fa);
    total++; if (lat !== 5 || ens !== 4 || fa !== 16'h203) begin bad++;
      $display("FAIL sw_split_timing: lat=%0d ens=%0d addr=%h want 5 4 0203", lat, ens, fa); end
    total++; if (resp_fault !== 1'b0 || resp_misalign !== 1'b0) begin bad++;
      $display("FAIL sw_split_flags: f=%b m=%b want 0 0", resp_fault, resp_misalign); end
    ack();
    total++; if ({mem[16'h207], mem[16'h206], mem[16'h205], mem[16'h204], mem[16'h203], mem[16'h202]} !== 48'h00DEADBEEF00) begin bad++;
      $display("FAIL sw_split_mem: got %h want 00DEADBEEF00",
               {mem[16'h207], mem[16'h206], mem[16'h205], mem[16'h204], mem[16'h203], mem[16'h202]}); end
    // Halfword split across the top of the RAM wraps to address 0.
    issue(1'b1, 3'b001, 64'hFFFF, 64'hA55A);
    wait_resp(lat, ens, fa);
    ack();
    total++; if (lat !== 3 || ens !== 2 || mem[16'hFFFF] !== 8'h5A || mem[16'h0] !== 8'hA5) begin bad++;
      $display("FAIL sh_wrap: lat=%0d ens=%0d ffff=%h 0000=%h want 3 2 5A A5", lat, ens, mem[16'hFFFF], mem[16'h0]); end
  endtask

  task automatic test_faults();
    int lat, ens; logic [15:0] fa;
    issue(1'b0, 3'b011, 64'h1_0000, 64'h0);
    wait_resp(lat, ens, fa);
    total++; if (lat !== 1 || ens !== 0 || resp_fault !== 1'b1 || resp_rdata !== 64'h0) begin bad++;
      $display("FAIL fault_range: lat=%0d ens=%0d f=%b rdata=%h want 1 0 1 0", lat, ens, resp_fault, resp_rdata); end
    ack();
    issue(1'b0, 3'b111, 64'h0, 64'h0);
    wait_resp(lat, ens, fa);
    total++; if (lat !== 1 || ens !== 0 || resp_fault !== 1'b1) begin bad++;
      $display("FAIL fault_wid111: lat=%0d ens=%0d f=%b want 1 0 1", lat, ens, resp_fault); end
    ack();
    issue(1'b1, 3'b100, 64'h20, 64'hFF);
    wait_resp(lat, ens, fa);
    total++; if (lat !== 1 || ens !== 0 || resp_fault !== 1'b1 || mem[16'h20] !== 8'h00) begin bad++;
      $display("FAIL fault_store_u: lat=%0d ens=%0d f=%b mem=%h want 1 0 1 00", lat, ens, resp_fault, mem[16'h20]); end
    ack();
    unalign_inj = 1'b1;
    issue(1'b0, 3'b011, 64'h100, 64'h0);
    wait_resp(lat, ens, fa);
    unalign_inj = 1'b0;
    total++; if (lat !== 3 || resp_fault !== 1'b1 || resp_rdata !== 64'h0) begin bad++;
      $display("FAIL fault_unalign: lat=%0d f=%b rdata=%h want 3 1 0", lat, resp_fault, resp_rdata); end
    ack();
    total++; if (resp_fault !== 1'b0) begin bad++;
      $display("FAIL fault_clear: got %b want 0", resp_fault); end
  endtask

  task automatic test_no_split();
    @(negedge clk);
    req_we = 1'b1; req_wid = 3'b001; req_addr = 64'h201; req_wdata = 64'h1234; req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    @(negedge clk);
    total++; if ({resp_valid0, resp_misalign0, resp_fault0, ram_en0, req_ready0} !== 5'b11000) begin bad++;
      $display("FAIL nosplit_sh: got v/m/f/en/rdy=%b want 11000",
               {resp_valid0, resp_misalign0, resp_fault0, ram_en0, req_ready0}); end
    @(negedge clk); resp_ready0 = 1'b1; @(posedge clk); #1 resp_ready0 = 1'b0;
    total++; if ({resp_valid0, resp_misalign0, req_ready0} !== 3'b001) begin bad++;
      $display("FAIL nosplit_ack: got v/m/rdy=%b want 001", {resp_valid0, resp_misalign0, req_ready0}); end
    @(negedge clk);
    req_we = 1'b0; req_wid = 3'b011; req_addr = 64'h1_0000; req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    @(negedge clk);
    total++; if ({resp_valid0, resp_fault0, resp_misalign0, ram_en0} !== 4'b1100) begin bad++;
      $display("FAIL nosplit_range: got v/f/m/en=%b want 1100", {resp_valid0, resp_fault0, resp_misalign0, ram_en0}); end
    @(negedge clk); resp_ready0 = 1'b1; @(posedge clk); #1 resp_ready0 = 1'b0;
  endtask

  task automatic test_hold_resp();
    int lat, ens; logic [15:0] fa;
    issue(1'b1, 3'b000, 64'h400, 64'h55);
    wait_resp(lat, ens, fa);
    total++; if (lat !== 2) begin bad++;
      $display("FAIL hold_lat: got %0d want 2", lat); end
    req_we = 1'b1; req_wid = 3'b000; req_addr = 64'h500; req_wdata = 64'h77; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if ({resp_valid, req_ready, ram_en} !== 3'b100) begin bad++;
        $display("FAIL hold_cycle%0d: got v/rdy/en=%b want 100", c, {resp_valid, req_ready, ram_en}); end
    end
    req_valid = 1'b0;
    ack();
    repeat (3) @(negedge clk);
    total++; if (resp_valid !== 1'b0 || mem[16'h400] !== 8'h55 || mem[16'h500] !== 8'h00) begin bad++;
      $display("FAIL hold_after: valid=%b m400=%h m500=%h want 0 55 00", resp_valid, mem[16'h400], mem[16'h500]); end
  endtask

  task automatic test_reset_mid_split();
    int seen;
    issue(1'b1, 3'b010, 64'h601, 64'hA1B2C3D4);
    @(negedge clk);
    total++; if (ram_en !== 1'b1 || ram_addr !== 16'h601 || ram_enwr !== 1'b0) begin bad++;
      $display("FAIL rstsplit_c0: en=%b addr=%h enwr=%b want 1 0601 0", ram_en, ram_addr, ram_enwr); end
    @(negedge clk);
    total++; if (ram_en !== 1'b1 || ram_addr !== 16'h602) begin bad++;
      $display("FAIL rstsplit_c1: en=%b addr=%h want 1 0602", ram_en, ram_addr); end
    rst = 1'b1;
    #1;
    total++; if ({ram_en, req_ready, resp_valid} !== 3'b010) begin bad++;
      $display("FAIL rstsplit_drop: got en/rdy/v=%b want 010", {ram_en, req_ready, resp_valid}); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || ram_en !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++;
      $display("FAIL rstsplit_quiet: %0d cycles with resp/en activity want 0", seen); end
    total++; if (mem[16'h601] !== 8'hD4 || mem[16'h603] !== 8'h00 || mem[16'h604] !== 8'h00) begin bad++;
      $display("FAIL rstsplit_mem: 601=%h 603=%h 604=%h want D4 00 00", mem[16'h601], mem[16'h603], mem[16'h604]); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    req_valid = 1'b0; req_valid0 = 1'b0; req_we = 1'b0; req_wid = 3'b000;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; resp_ready0 = 1'b0;
    unalign_inj = 1'b0;
    test_reset();
    test_load();
    test_byte_loads();
    test_store_aligned();
    test_split_store();
    test_faults();
    test_no_split();
    test_hold_resp();
    test_reset_mid_split();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
